// File: rtl/song_tutor.sv
// song_tutor: parametrised piano tutor sequencer.
// Steps through a note sequence held in an external ROM. Each song has its own
// slot of 2**ADDR_W entries, and the song is chosen with song_sel when START is
// seen. The tutor shows the expected note on Led and waits for the player to
// press it and then release every key. It also detects wrong notes, keeps a
// saturating error count, supports a strict mode in which a wrong note restarts
// the song, and detects the end of the song.
//
// Ports:
//   CLK, RESET      clock, synchronous active-high reset
//   START           restart the tutor (level, sampled every cycle)
//   song_sel        song select, latched when START is seen
//   strict          1 = a wrong note restarts the song at index 0
//   note            pressed note code (NONE_CODE when released)
//   rom_addr        registered ROM address {song, idx}
//   rom_data        ROM read data, valid in the cycle after rom_addr updates
//   Led             one-hot expected note (codes 1..8), 8'hFF when done
//   expected        expected note code
//   note_idx        current position in the song
//   err_count       wrong presses since START, saturating
//   correct_pulse   one-cycle pulse on an accepted correct press
//   wrong_pulse     one-cycle pulse on each new wrong press
//   busy            high in every state except IDLE and DONE
//   done            high in DONE
module song_tutor #(
  parameter int NOTE_W    = 4,
  parameter int ADDR_W    = 7,
  parameter int SEL_W     = 1,
  parameter int NONE_CODE = 0,
  parameter int END_CODE  = 15,
  parameter int ERR_W     = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [SEL_W-1:0]        song_sel,
  input  logic                    strict,
  input  logic [NOTE_W-1:0]       note,
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  input  logic [NOTE_W-1:0]       rom_data,
  output logic [7:0]              Led,
  output logic [NOTE_W-1:0]       expected,
  output logic [ADDR_W-1:0]       note_idx,
  output logic [ERR_W-1:0]        err_count,
  output logic                    correct_pulse,
  output logic                    wrong_pulse,
  output logic                    busy,
  output logic                    done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESS,
    S_RELEASE,
    S_WRELEASE,
    S_DONE
  } state_t;

  state_t                    r_state;
  logic [SEL_W-1:0]          r_song;
  logic [ADDR_W-1:0]         r_idx;
  logic [SEL_W+ADDR_W-1:0]   r_rom_addr;
  logic [7:0]                r_led;
  logic [NOTE_W-1:0]         r_expected;
  logic [ERR_W-1:0]          r_err;
  logic                      r_correct;
  logic                      r_wrong;
  logic                      r_busy;
  logic                      r_done;

  logic [7:0]                w_led_dec;
  logic                      w_note_none;
  logic                      w_rom_end;

  assign w_note_none = (note == NOTE_W'(NONE_CODE));
  assign w_rom_end   = (rom_data == NOTE_W'(END_CODE));

  // Codes 1..8 light bit code-1. Every other code leaves the LEDs dark.
  always_comb begin
    w_led_dec = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (rom_data == NOTE_W'(i + 1)) w_led_dec[i] = 1'b1;
    end
  end

  // busy and done are registered alongside the state. Every transition
  // therefore sets them explicitly for the state it is entering.
  always_ff @(posedge CLK) begin
    r_correct <= 1'b0;
    r_wrong   <= 1'b0;
    if (RESET) begin
      r_state    <= S_IDLE;
      r_song     <= '0;
      r_idx      <= '0;
      r_rom_addr <= '0;
      r_led      <= '0;
      r_expected <= '0;
      r_err      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else if (START) begin
      r_song  <= song_sel;
      r_idx   <= '0;
      r_err   <= '0;
      r_state <= S_FETCH;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_led <= '0;
        end
        S_FETCH: begin
          r_rom_addr <= {r_song, r_idx};
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (w_rom_end) begin
            r_led   <= '1;
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_expected <= rom_data;
            r_led      <= w_led_dec;
            r_state    <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (!w_note_none) begin
            if (note == r_expected) begin
              r_correct <= 1'b1;
              r_state   <= S_RELEASE;
            end else begin
              r_wrong <= 1'b1;
              if (r_err != '1) r_err <= r_err + ERR_W'(1);
              r_state <= S_WRELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (w_note_none) begin
            // A song that fills its whole slot ends here instead of wrapping.
            if (r_idx == '1) begin
              r_led   <= '1;
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + ADDR_W'(1);
              r_state <= S_FETCH;
            end
          end
        end
        S_WRELEASE: begin
          // Going straight from the wrong key to the right one is ignored.
          // The keys have to be released first.
          if (w_note_none) begin
            if (strict) begin
              r_idx   <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state <= S_PRESS;
            end
          end
        end
        S_DONE: begin
          r_led <= '1;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr      = r_rom_addr;
  assign Led           = r_led;
  assign expected      = r_expected;
  assign note_idx      = r_idx;
  assign err_count     = r_err;
  assign correct_pulse = r_correct;
  assign wrong_pulse   = r_wrong;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_song_tutor.sv
module tb_song_tutor;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       START;
  logic [0:0] song_sel;
  logic       strict;
  logic [3:0] note;
  logic [7:0] rom_addr;
  logic [3:0] rom_data;
  logic [7:0] Led;
  logic [3:0] expected;
  logic [6:0] note_idx;
  logic [7:0] err_count;
  logic       correct_pulse;
  logic       wrong_pulse;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [3:0] mem [0:255];
  assign rom_data = mem[rom_addr];

  song_tutor #(
    .NOTE_W(4), .ADDR_W(7), .SEL_W(1), .NONE_CODE(0), .END_CODE(15), .ERR_W(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .song_sel(song_sel), .strict(strict),
    .note(note), .rom_addr(rom_addr), .rom_data(rom_data), .Led(Led),
    .expected(expected), .note_idx(note_idx), .err_count(err_count),
    .correct_pulse(correct_pulse), .wrong_pulse(wrong_pulse), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  // Count the pulses the DUT produces.
  int n_corr = 0;
  int n_wrong = 0;
  always @(negedge CLK) begin
    if (correct_pulse === 1'b1) n_corr++;
    if (wrong_pulse === 1'b1) n_wrong++;
  end

  // Behavioural model. It works on whole player actions (press, release),
  // not on clock cycles.
  int m_song, m_idx, m_err, m_corr, m_wrong;
  bit m_done;
  int m_pend;  // 0 none, 1 advance, 2 wrong pending release

  function automatic logic [7:0] led_of(int code);
    if (code >= 1 && code <= 8) return 8'(1 << (code - 1));
    return 8'h00;
  endfunction

  function automatic int cur_code();
    return int'(mem[m_song * 128 + m_idx]);
  endfunction

  function automatic logic [7:0] m_led();
    return m_done ? 8'hFF : led_of(cur_code());
  endfunction

  task automatic m_start(int s);
    m_song = s; m_idx = 0; m_err = 0; m_pend = 0;
    m_done = (cur_code() == 15);
  endtask

  task automatic m_press(int n);
    if (m_done || n == 0 || m_pend != 0) return;
    if (n == cur_code()) begin
      m_corr++; m_pend = 1;
    end else begin
      m_wrong++; m_pend = 2;
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic m_release(bit strict_now);
    if (m_pend == 1) begin
      if (m_idx == 127) m_done = 1;
      else begin
        m_idx++;
        if (cur_code() == 15) m_done = 1;
      end
    end else if (m_pend == 2 && strict_now) begin
      m_idx = 0;
      if (cur_code() == 15) m_done = 1;
    end
    m_pend = 0;
  endtask

  // Stimulus helpers
  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic do_start(int s);
    song_sel = 1'(s); START = 1'b1; tick();
    START = 1'b0; m_start(s);
    tick(); tick(); tick();
  endtask

  task automatic play(int n, int hold);
    note = 4'(n); m_press(n);
    for (int i = 0; i < hold; i++) tick();
    note = 4'd0; m_release(strict);
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) mem[i] = 4'd15;
  endtask

  task automatic test_reset();
    START = 1'b1; song_sel = 1'b1; RESET = 1'b0;
    tick(); tick(); tick();
    RESET = 1'b1; START = 1'b1; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (Led !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", Led); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_count); end
    checks++; if (rom_addr !== 8'd0 || expected !== 4'd0 || note_idx !== 7'd0)
      begin errors++; $display("FAIL reset_regs: addr %h exp %h idx %0d expected all 0", rom_addr, expected, note_idx); end
    RESET = 1'b0; START = 1'b0; tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle: busy %b expected 0", busy); end
  endtask

  task automatic test_correct_song();
    logic [7:0] leds [3];
    leds[0] = 8'h01; leds[1] = 8'h02; leds[2] = 8'h04;
    clear_rom();
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd15;
    strict = 1'b0; n_corr = 0; n_wrong = 0; m_corr = 0; m_wrong = 0;
    song_sel = 1'b0; START = 1'b1; tick(); START = 1'b0; m_start(0);
    tick();
    checks++; if (expected !== 4'd0) begin errors++; $display("FAIL latency_early: expected %0d required 0", expected); end
    tick();
    checks++; if (expected !== 4'd1 || Led !== 8'h01)
      begin errors++; $display("FAIL latency: expected %0d Led %h required 1 / 01", expected, Led); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (Led !== leds[k] || note_idx !== 7'(k))
        begin errors++; $display("FAIL song_step%0d: Led %h idx %0d required %h %0d", k, Led, note_idx, leds[k], k); end
      play(k + 1, 2);
    end
    checks++; if (note_idx !== 7'd3) begin errors++; $display("FAIL song_idx_end: got %0d required 3", note_idx); end
    checks++; if (done !== 1'b1 || busy !== 1'b0 || Led !== 8'hFF)
      begin errors++; $display("FAIL song_done: done %b busy %b Led %h required 1 0 FF", done, busy, Led); end
    checks++; if (n_corr != 3 || n_wrong != 0 || err_count !== 8'd0)
      begin errors++; $display("FAIL song_pulses: corr %0d wrong %0d err %0d required 3 0 0", n_corr, n_wrong, err_count); end
  endtask

  task automatic test_lenient();
    strict = 1'b0; n_corr = 0; n_wrong = 0;
    do_start(0);
    play(1, 1);
    note = 4'd5; for (int i = 0; i < 10; i++) tick();
    checks++; if (n_wrong != 1 || err_count !== 8'd1)
      begin errors++; $display("FAIL lenient_held: wrong %0d err %0d required 1 1", n_wrong, err_count); end
    note = 4'd2; tick(); tick();
    checks++; if (n_corr != 1) begin errors++; $display("FAIL wrong_to_right: corr %0d required 1", n_corr); end
    note = 4'd0; tick(); tick();
    checks++; if (note_idx !== 7'd1 || Led !== 8'h02)
      begin errors++; $display("FAIL lenient_stay: idx %0d Led %h required 1 02", note_idx, Led); end
    play(2, 1);
    checks++; if (note_idx !== 7'd2 || err_count !== 8'd1 || n_corr != 2 || n_wrong != 1)
      begin errors++; $display("FAIL lenient_adv: idx %0d err %0d corr %0d wrong %0d required 2 1 2 1", note_idx, err_count, n_corr, n_wrong); end
  endtask

  task automatic test_strict();
    clear_rom();
    mem[0] = 4'd1; mem[1] = 4'd2; mem[2] = 4'd3; mem[3] = 4'd4;
    strict = 1'b1;
    do_start(0);
    play(1, 1); play(2, 1);
    checks++; if (note_idx !== 7'd2) begin errors++; $display("FAIL strict_pre: idx %0d required 2", note_idx); end
    play(6, 3);
    checks++; if (note_idx !== 7'd0 || rom_addr !== 8'd0 || err_count !== 8'd1 || Led !== 8'h01)
      begin errors++; $display("FAIL strict_restart: idx %0d addr %0d err %0d Led %h required 0 0 1 01", note_idx, rom_addr, err_count, Led); end
    strict = 1'b0;
  endtask

  task automatic test_song_select();
    mem[128] = 4'd8; mem[129] = 4'd15;
    do_start(0);
    play(7, 1);
    checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL sel_pre_err: got %0d required 1", err_count); end
    do_start(1);
    checks++; if (rom_addr !== 8'd128 || Led !== 8'h80 || err_count !== 8'd0)
      begin errors++; $display("FAIL sel_song1: addr %0d Led %h err %0d required 128 80 0", rom_addr, Led, err_count); end
    play(8, 1);
    checks++; if (done !== 1'b1 || Led !== 8'hFF)
      begin errors++; $display("FAIL sel_done: done %b Led %h required 1 FF", done, Led); end
  endtask

  task automatic test_saturation();
    n_wrong = 0;
    do_start(0);
    for (int i = 0; i < 300; i++) begin
      note = 4'd9; tick(); note = 4'd0; tick(); tick();
    end
    checks++; if (err_count !== 8'd255 || n_wrong != 300)
      begin errors++; $display("FAIL saturation: err %0d wrong %0d required 255 300", err_count, n_wrong); end
  endtask

  task automatic test_no_terminator();
    for (int i = 0; i < 128; i++) mem[128 + i] = 4'($urandom_range(1, 14));
    strict = 1'b0;
    do_start(1);
    for (int i = 0; i < 127; i++) play(int'(mem[128 + i]), 1);
    checks++; if (note_idx !== 7'd127 || done !== 1'b0)
      begin errors++; $display("FAIL full_last: idx %0d done %b required 127 0", note_idx, done); end
    play(int'(mem[255]), 1);
    checks++; if (done !== 1'b1 || note_idx !== 7'd127 || Led !== 8'hFF)
      begin errors++; $display("FAIL full_done: done %b idx %0d Led %h required 1 127 FF", done, note_idx, Led); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int len, s, n;
      s = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 12));
      for (int i = 0; i < 128; i++) mem[s * 128 + i] = 4'd15;
      for (int i = 0; i < len; i++) mem[s * 128 + i] = 4'($urandom_range(1, 14));
      n_corr = 0; n_wrong = 0; m_corr = 0; m_wrong = 0;
      do_start(s);
      for (int step = 0; step < 40 && !m_done; step++) begin
        strict = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 9) < 7) n = cur_code();
        else begin
          n = int'($urandom_range(1, 14));
          if (n == cur_code()) n = (n % 14) + 1;
        end
        play(n, int'($urandom_range(1, 4)));
        checks++; if (Led !== m_led() || note_idx !== 7'(m_idx) || err_count !== 8'(m_err) || done !== m_done)
          begin errors++; $display("FAIL rand_state it%0d step%0d: Led %h idx %0d err %0d done %b required %h %0d %0d %b",
                 it, step, Led, note_idx, err_count, done, m_led(), m_idx, m_err, m_done); end
      end
      checks++; if (n_corr != m_corr || n_wrong != m_wrong)
        begin errors++; $display("FAIL rand_pulses it%0d: corr %0d wrong %0d required %0d %0d", it, n_corr, n_wrong, m_corr, m_wrong); end
    end
    strict = 1'b0;
  endtask

  initial begin
    RESET = 1'b1; START = 1'b0; song_sel = 1'b0; strict = 1'b0; note = 4'd0;
    clear_rom();
    tick(); tick();
    test_reset();
    test_correct_song();
    test_lenient();
    test_strict();
    test_song_select();
    test_saturation();
    test_no_terminator();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/song_tutor.md
Name: song_tutor

Overview:
- Parametrised successor to the fixed-song piano tutor FSM.
- Steps through a note sequence stored in an external synchronous ROM, selectable among NUM_SONGS songs. Shows the expected note on Led and waits for the player to press the correct key and then release all keys.
- Adds wrong-note detection with a saturating error count, strict mode (a wrong note restarts the song), end-of-song detection and a done flag.
- Sits between the switch/key decoder (note) and the LED/status display.

Parameters:
NOTE_W, 4, width of note codes
ADDR_W, 7, per-song index width; MAX_LEN = 2**ADDR_W notes per song slot
SEL_W, 1, song-select width; NUM_SONGS = 2**SEL_W
NONE_CODE, 0, note code meaning "no key pressed"
END_CODE, 15, ROM code terminating a song
ERR_W, 8, error counter width

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
START  in  1  restart the tutor (level, sampled each cycle)
song_sel  in  SEL_W  song select, sampled only when START is seen
strict  in  1  1 = a wrong note restarts the song at index 0
note  in  NOTE_W  currently pressed note code (NONE_CODE when released)
rom_addr  out  SEL_W+ADDR_W  registered ROM address = {song, idx}
rom_data  in  NOTE_W  ROM read data, valid one cycle after rom_addr is registered
Led  out  8  one-hot expected note: codes 1..8 light bit code-1; other codes give 0
expected  out  NOTE_W  expected note code
note_idx  out  ADDR_W  current position in the song
err_count  out  ERR_W  wrong presses since START, saturates at all-ones
correct_pulse  out  1  one-cycle pulse on an accepted correct press
wrong_pulse  out  1  one-cycle pulse on each new wrong press
busy  out  1  high in every state except IDLE and DONE
done  out  1  high in DONE

Behaviour:
- Reset:
  - RESET is synchronous and takes priority over START.
  - State goes to IDLE. All outputs go to 0: rom_addr, Led, expected, note_idx, err_count, pulses, busy, done.
- START (any state):
  - Latch song_sel into song_r.
  - Set idx=0 and err_count=0; clear pulses.
  - Next state FETCH.
  - While START is held, the FSM stays in FETCH.
- State IDLE: Led=0, waits for START.
- State FETCH: rom_addr <= {song_r, idx}. Next state WAIT.
- State WAIT: rom_data is valid this cycle.
  - If rom_data==END_CODE: next state DONE.
  - Otherwise: expected <= rom_data, Led <= decode(rom_data), next state PRESS.
  - Latency: expected and Led are valid after the 2nd edge following the START-sampling edge.
- State PRESS:
  - note==expected: correct_pulse=1 for one cycle, next state RELEASE.
  - note != NONE_CODE and note != expected: wrong_pulse=1 for one cycle, err_count+1 (saturating), next state WRELEASE.
  - note==NONE_CODE: stay.
- State RELEASE (waits for note==NONE_CODE):
  - If idx == MAX_LEN-1: go to DONE. This handles a song with no terminator; no wrap-around.
  - Otherwise idx+1 and go to FETCH.
- State WRELEASE (waits for note==NONE_CODE):
  - strict=1: idx=0, next state FETCH. err_count is kept.
  - strict=0: return to PRESS with idx unchanged.
  - A held wrong key counts exactly once.
- State DONE: done=1, busy=0, Led=8'hFF. Holds until START or RESET.
- Other rules:
  - note_idx mirrors idx.
  - A note change directly from wrong to correct without passing through NONE_CODE is not accepted; WRELEASE requires NONE_CODE first.
  - strict is sampled live in WRELEASE.
  - The ROM is never read outside FETCH.

Test Plan:
- Reset: assert RESET with START=1 simultaneously -> state IDLE; Led=0, done=0, busy=0, err_count=0.
- Correct song: song 0 ROM = {1,2,3,END}; START; play 1,0,2,0,3,0 -> Led sequence 8'h01, 8'h02, 8'h04; three correct_pulses; note_idx 0→1→2→3; then done=1, Led=8'hFF, err_count=0.
- Lenient wrong note: strict=0, expected=2; press 5 held 10 cycles, release, press 2, release -> exactly one wrong_pulse, err_count=1, note_idx advances to next.
- Strict restart: strict=1, at idx=2 press wrong note then release -> note_idx=0, rom_addr={song,0}, err_count=1, Led back to first note.
- Song select and START mid-song: song_sel=1 ROM base 128 = {8,END}; START while in PRESS of song 0 -> rom_addr=128, Led=8'h80, err_count cleared; play 8,0 -> done.
- Saturation and no terminator: 300 wrong presses -> err_count=255; a full 128-note song without END -> done after the 128th release, no wrap.
